display_scan_controller: RTL and testbench
==========================================

# display_scan_controller

Time-multiplexes one shared 4-bit-to-7-segment decoder across a 4-digit common-anode display. Holds a 16-bit BCD value (four nibbles), steps the decoder through each digit with dead-time between digits to prevent ghosting, and drives the active-low segment and digit-enable pins. Sits between the decrypted-value producer, the existing segment decoder instance and the board pins. New values enter through a request/acknowledge handshake and take effect only at frame boundaries, so the display never tears.

## Interface
- SCAN_DIV, 1000: drive cycles per digit; must be ≥1.
- DEAD_CYCLES, 4: blank cycles before each digit's drive; must be ≥1.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- Load_req  in  1  requester holds high with Load_data stable until Load_ack.
- Load_data  in  16  four BCD nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- Load_ack  out  1  one-cycle pulse; Load_data has been captured into the pending register.
- Blank  in  1  high forces all digits off; scanning continues.
- Dec_code  out  4  nibble presented to the shared decoder input.
- Dec_seg  in  7  combinational decoder output, active-low (7'b1111111 = all off).
- Seg_out  out  7  registered segment pins, active-low.
- Digit_en  out  4  registered digit enables, active-low, one-hot-low when driving.
- Frame_done  out  1  one-cycle pulse at the end of digit 3's drive phase.

## Operation
- State: phase {DEAD, DRIVE}, digit index 0..3, cycle counter, active register (16 bits), pending register (16 bits) with valid flag.
- DEAD, digit i:
  - Dec_code = active[4i+3:4i].
  - Seg_out = 7'h7F, Digit_en = 4'hF.
  - After DEAD_CYCLES cycles, go to DRIVE.
- DRIVE, digit i:
  - Dec_code is held.
  - Every cycle: Seg_out <= Dec_seg and Digit_en <= ~(4'b0001 << i).
  - If Blank is high, force Seg_out = 7'h7F and Digit_en = 4'hF instead.
  - After SCAN_DIV cycles, go to DEAD of digit (i+1) mod 4.
- Frame boundary (leaving DRIVE of digit 3):
  - Frame_done pulses.
  - If pending is valid: active <= pending and valid clears, on the same edge. Digit 0 of the next frame shows the new value.
- Handshake:
  - Load_req is accepted on an edge where Load_req=1 and pending is not valid.
  - On accept: pending <= Load_data, valid is set, Load_ack=1 for the next cycle.
  - While pending is valid, Load_req is not acknowledged; the requester keeps holding.
  - At most one accept per frame.
- Simultaneous accept and boundary with pending valid: the boundary transfer wins. The request is accepted on the following edge and applies at the next boundary.
- Dec_seg values are passed through unchanged; the block does not interpret codes above 9.
- The cycle counter needs width clog2(max(SCAN_DIV, DEAD_CYCLES)). It resets to 0 on every phase change.

## Timing
- Reset values: Seg_out=7'h7F, Digit_en=4'hF, Dec_code=4'h0, Load_ack=0, Frame_done=0, active=16'h0000, pending valid=0, phase=DEAD, digit=0, counter=0.
- The first DRIVE begins DEAD_CYCLES cycles after rst deasserts.
- Digit period = DEAD_CYCLES+SCAN_DIV cycles; frame period = 4×(DEAD_CYCLES+SCAN_DIV).
- Dec_code changes only on entry to DEAD, so Dec_seg has settled for ≥DEAD_CYCLES cycles before it is registered.
- Load_ack: 1 cycle after the accepting edge.
- Load-to-display latency: from ack to the next frame boundary (≤1 frame), plus DEAD_CYCLES+1 cycles.
- Blank takes effect on Seg_out/Digit_en one cycle after it is sampled.
- rst mid-frame returns everything to the reset values on the next edge. Any pending load is discarded and must be re-requested.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - During DRIVE of digit i (i=3..1), the digit is blanked (Seg_out=7'h7F, Digit_en=4'hF) when active nibble i and every higher nibble are 0.
  - Digit 0 is always driven.
- LEADING_ZERO_BLANK_EN undefined: all four digits are always driven, subject to Blank.

## Test plan
All scenarios use SCAN_DIV=3, DEAD_CYCLES=1.
- Reset release, no load:
  - Cycle 1 after reset: Digit_en=4'b1110 with Seg_out=Dec_seg for code 0.
  - The digit sequence is 1110, 1101, 1011, 0111, each 3 cycles separated by 1 cycle of 4'hF.
  - Frame_done pulses every 16 cycles.
- Load 16'h1234 mid-frame:
  - Load_ack pulses once.
  - Dec_code keeps giving 0 until the frame boundary, then gives 4,3,2,1 for digits 0..3.
- Back-to-back loads 16'h1111 then 16'h2222:
  - The second request waits unacked until the boundary applies 1111.
  - 2222 applies at the following boundary.
- Load_req on the same edge as a boundary with pending valid: the ack comes one cycle after the boundary and the value applies one frame later.
- Blank=1 for a full frame: Digit_en=4'hF and Seg_out=7'h7F throughout; Frame_done cadence is unchanged.
- Active=16'h0070:
  - With LEADING_ZERO_BLANK_EN, digits 3 and 2 stay off while digits 1 and 0 are driven.
  - Without it, all four digits are driven.

Source files
------------

// File: rtl/display_scan_controller.sv
// Time-multiplexed 4-digit common-anode scan controller with frame-synchronous value loading.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zero digits 3..1).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// PH_DEAD   | all digits off while the decoder settles on the new nibble
// PH_DRIVE  | current digit enabled, decoder output registered to pins
module display_scan_controller #(
    parameter int SCAN_DIV    = 1000,
    parameter int DEAD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Load_req,
    input  logic [15:0] Load_data,
    output logic        Load_ack,
    input  logic        Blank,
    output logic [3:0]  Dec_code,
    input  logic [6:0]  Dec_seg,
    output logic [6:0]  Seg_out,
    output logic [3:0]  Digit_en,
    output logic        Frame_done
);

    localparam int MAX_DIV = (SCAN_DIV > DEAD_CYCLES) ? SCAN_DIV : DEAD_CYCLES;
    localparam int CNT_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_CYCLES - 1);

    localparam logic [0:0] PH_DEAD  = 1'b0;
    localparam logic [0:0] PH_DRIVE = 1'b1;

    logic [0:0]       phase;
    logic [1:0]       digit;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      active;
    logic [15:0]      pending;
    logic             pend_valid;

    logic phase_end;
    logic frame_end;
    logic accept;
    logic lz_blank;
    logic drive_on;

    assign phase_end = (phase == PH_DEAD) ? (cnt == DEAD_LAST) : (cnt == DRIVE_LAST);
    assign frame_end = (phase == PH_DRIVE) && (cnt == DRIVE_LAST) && (digit == 2'd3);
    assign accept    = Load_req && !pend_valid;

    // Only changes when digit or active changes, i.e. on entry to DEAD.
    assign Dec_code = active[{digit, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        lz_blank = 1'b0;
        case (digit)
            2'd3:    lz_blank = (active[15:12] == 4'h0);
            2'd2:    lz_blank = (active[15:8] == 8'h00);
            2'd1:    lz_blank = (active[15:4] == 12'h000);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    assign drive_on = (phase == PH_DRIVE) && !Blank && !lz_blank;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase      <= PH_DEAD;
            digit      <= 2'd0;
            cnt        <= '0;
            active     <= 16'h0000;
            pending    <= 16'h0000;
            pend_valid <= 1'b0;
            Load_ack   <= 1'b0;
            Frame_done <= 1'b0;
            Seg_out    <= 7'h7F;
            Digit_en   <= 4'hF;
        end else begin
            Load_ack   <= accept;
            Frame_done <= frame_end;

            if (drive_on) begin
                Seg_out  <= Dec_seg;
                Digit_en <= ~(4'b0001 << digit);
            end else begin
                Seg_out  <= 7'h7F;
                Digit_en <= 4'hF;
            end

            if (phase_end) begin
                cnt <= '0;
                if (phase == PH_DRIVE) begin
                    phase <= PH_DEAD;
                    digit <= digit + 2'd1;
                end else begin
                    phase <= PH_DRIVE;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end

            // Boundary transfer and accept are mutually exclusive: accept needs valid low.
            if (frame_end && pend_valid) begin
                active     <= pending;
                pend_valid <= 1'b0;
            end else if (accept) begin
                pending    <= Load_data;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller: a frame-position model pushes expected
// pin values per cycle; the monitor pops and compares after each rising edge.
module tb_display_scan_controller;

    localparam int SCAN  = 3;
    localparam int DEAD  = 1;
    localparam int PER   = SCAN + DEAD;
    localparam int FRAME = 4 * PER;

    logic        clk = 1'b0;
    logic        rst;
    logic        Load_req;
    logic [15:0] Load_data;
    logic        Load_ack;
    logic        Blank;
    logic [3:0]  Dec_code;
    logic [6:0]  Dec_seg;
    logic [6:0]  Seg_out;
    logic [3:0]  Digit_en;
    logic        Frame_done;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] en;
        logic       ack;
        logic       fd;
        logic [3:0] code;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] load_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_loads  = 0;
    int n_acks   = 0;

    int          m_k = 0;
    logic [15:0] m_active = 16'h0;
    logic [15:0] m_pend = 16'h0;
    logic        m_pvalid = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_lut(input logic [3:0] c);
        case (c)
            4'h0: seg_lut = 7'h40;  4'h1: seg_lut = 7'h79;
            4'h2: seg_lut = 7'h24;  4'h3: seg_lut = 7'h30;
            4'h4: seg_lut = 7'h19;  4'h5: seg_lut = 7'h12;
            4'h6: seg_lut = 7'h02;  4'h7: seg_lut = 7'h78;
            4'h8: seg_lut = 7'h00;  4'h9: seg_lut = 7'h10;
            4'hA: seg_lut = 7'h08;  4'hB: seg_lut = 7'h03;
            4'hC: seg_lut = 7'h46;  4'hD: seg_lut = 7'h21;
            4'hE: seg_lut = 7'h06;  default: seg_lut = 7'h0E;
        endcase
    endfunction

    assign Dec_seg = seg_lut(Dec_code);

    display_scan_controller #(.SCAN_DIV(SCAN), .DEAD_CYCLES(DEAD)) dut (
        .clk(clk), .rst(rst), .Load_req(Load_req), .Load_data(Load_data),
        .Load_ack(Load_ack), .Blank(Blank), .Dec_code(Dec_code), .Dec_seg(Dec_seg),
        .Seg_out(Seg_out), .Digit_en(Digit_en), .Frame_done(Frame_done)
    );

    function automatic logic [3:0] nib(input logic [15:0] a, input int d);
        nib = a[d*4 +: 4];
    endfunction

    function automatic logic lz(input logic [15:0] a, input int d);
`ifdef LEADING_ZERO_BLANK_EN
        lz = (d > 0) && ((a >> (4 * d)) == 16'h0);
`else
        lz = 1'b0;
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic model_push();
        exp_t        e;
        int          p, d, q;
        logic        drv;
        logic [3:0]  onehot;
        if (rst) begin
            e.seg = 7'h7F; e.en = 4'hF; e.ack = 1'b0; e.fd = 1'b0; e.code = 4'h0;
            m_active = 16'h0; m_pvalid = 1'b0; m_k = 0;
        end else begin
            p = m_k % FRAME;
            d = p / PER;
            q = p % PER;
            drv = (q >= DEAD) && !Blank && !lz(m_active, d);
            onehot = 4'b0001 << d;
            e.en  = drv ? ~onehot : 4'hF;
            e.seg = drv ? seg_lut(nib(m_active, d)) : 7'h7F;
            e.fd  = (p == FRAME - 1);
            e.ack = Load_req && !m_pvalid;
            if (p == FRAME - 1 && m_pvalid) begin
                m_active = m_pend;
                m_pvalid = 1'b0;
            end else if (e.ack) begin
                m_pend   = Load_data;
                m_pvalid = 1'b1;
            end
            m_k++;
            e.code = nib(m_active, (m_k % FRAME) / PER);
        end
        exp_q.push_back(e);
    endtask

    task automatic step();
        exp_t o;
        model_push();
        @(posedge clk);
        #1;
        cyc++;
        o = exp_q.pop_front();
        check_eq("seg_out",    {25'd0, Seg_out},  {25'd0, o.seg});
        check_eq("digit_en",   {28'd0, Digit_en}, {28'd0, o.en});
        check_eq("load_ack",   {31'd0, Load_ack}, {31'd0, o.ack});
        check_eq("frame_done", {31'd0, Frame_done}, {31'd0, o.fd});
        check_eq("dec_code",   {28'd0, Dec_code}, {28'd0, o.code});
        if (Load_ack) n_acks++;
        if (Load_req && Load_ack) Load_req = 1'b0;
        if (!Load_req && load_q.size() > 0 && !rst) begin
            Load_data = load_q.pop_front();
            Load_req  = 1'b1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_load(input logic [15:0] v);
        load_q.push_back(v);
        n_loads++;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((load_q.size() > 0 || Load_req) && n < limit) begin
            step();
            n++;
        end
        check_eq("load_idle_timeout", {31'd0, Load_req}, 32'd0);
    endtask

    task automatic run_until_pos(input int pos, input int limit);
        int n = 0;
        while ((m_k % FRAME) != pos && n < limit) begin
            step();
            n++;
        end
    endtask

    initial begin
        rst = 1'b1; Load_req = 1'b0; Load_data = 16'h0; Blank = 1'b0;
        run(3);
        rst = 1'b0;
        run(2 * FRAME + 8);

        run_until_pos(6, 2 * FRAME);
        push_load(16'h1234);
        wait_idle(3 * FRAME);
        run(2 * FRAME);

        push_load(16'h1111);
        push_load(16'h2222);
        wait_idle(4 * FRAME);
        run(2 * FRAME);

        // Request raised exactly on a boundary edge while a value is still pending.
        run_until_pos(3, 2 * FRAME);
        push_load(16'hA5A5);
        wait_idle(3 * FRAME);
        run_until_pos(FRAME - 1, 2 * FRAME);
        Load_data = 16'h5678;
        Load_req  = 1'b1;
        n_loads++;
        wait_idle(3 * FRAME);
        run(2 * FRAME);

        Blank = 1'b1;
        run(FRAME + 4);
        Blank = 1'b0;
        run(FRAME);

        push_load(16'h0070);
        wait_idle(3 * FRAME);
        run(2 * FRAME);

        run_until_pos(4, 2 * FRAME);
        push_load(16'h9999);
        wait_idle(3 * FRAME);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(2 * FRAME);

        check_eq("ack_count", n_acks, n_loads);
        check_eq("load_drain", load_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
